axi3_sram_responder: RTL and testbench

//  AXI3 slave (responder) holding a word-addressed SRAM array; the memory-side counterpart of the DMA engines.

---
 rtl/axi3_sram_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_axi3_sram_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_sram_responder.sv
// AXI3 responder backed by a word-addressed SRAM.
// Independent read and write burst engines, one burst in flight each.
module axi3_sram_responder #(
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int ID_W           = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] awid_i,
    input  logic [31:0]     awaddr_i,
    input  logic [3:0]      awlen_i,
    input  logic [2:0]      awsize_i,
    input  logic [1:0]      awburst_i,
    input  logic            awvalid_i,
    output logic            awready_o,
    input  logic [ID_W-1:0] wid_i,
    input  logic [31:0]     wdata_i,
    input  logic [3:0]      wstrb_i,
    input  logic            wlast_i,
    input  logic            wvalid_i,
    output logic            wready_o,
    output logic [ID_W-1:0] bid_o,
    output logic [1:0]      bresp_o,
    output logic            bvalid_o,
    input  logic            bready_i,
    input  logic [ID_W-1:0] arid_i,
    input  logic [31:0]     araddr_i,
    input  logic [3:0]      arlen_i,
    input  logic [2:0]      arsize_i,
    input  logic [1:0]      arburst_i,
    input  logic            arvalid_i,
    output logic            arready_o,
    output logic [ID_W-1:0] rid_o,
    output logic [31:0]     rdata_o,
    output logic [1:0]      rresp_o,
    output logic            rlast_o,
    output logic            rvalid_o,
    input  logic            rready_i
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    logic [31:0] mem [DEPTH];

    // Write engine state
    w_state_t        w_state;
    idx_t            w_idx;
    logic [3:0]      w_len;
    logic [4:0]      w_cnt;
    logic            w_err;
    logic [ID_W-1:0] w_id;

    // Read engine state
    r_state_t        r_state;
    idx_t            r_idx;
    logic [3:0]      r_len;
    logic [3:0]      r_beat;
    logic [3:0]      r_beat_nxt;
    logic            r_err;

    logic            aw_fire;
    logic            aw_err;
    logic            w_fire;
    logic            w_len_ok;
    logic            ar_fire;
    logic            ar_err;
    logic            r_fire;
    idx_t            aw_idx;
    idx_t            ar_idx;
    idx_t            rd_idx;
    logic [31:0]     rd_word;
    logic            unused_bits;

    assign aw_fire  = awvalid_i && awready_o;
    assign aw_err   = (awsize_i != SIZE_4B) || (awburst_i != BURST_INCR);
    assign aw_idx   = awaddr_i[MEM_DEPTH_LOG2+1:2];
    assign w_fire   = wvalid_i && wready_o;
    assign w_len_ok = (w_cnt == {1'b0, w_len});

    assign ar_fire    = arvalid_i && arready_o;
    assign ar_err     = (arsize_i != SIZE_4B) || (arburst_i != BURST_INCR);
    assign ar_idx     = araddr_i[MEM_DEPTH_LOG2+1:2];
    assign r_fire     = rvalid_o && rready_i;
    assign r_beat_nxt = r_beat + 4'd1;

    // One SRAM read port: the AR address while idle, the running index otherwise
    assign rd_idx  = (r_state == R_IDLE) ? ar_idx : r_idx;
    assign rd_word = mem[rd_idx];

    // Byte offset, aliased upper address bits and WID carry no information here
    assign unused_bits = ^{wid_i,
                           awaddr_i[31:MEM_DEPTH_LOG2+2], awaddr_i[1:0],
                           araddr_i[31:MEM_DEPTH_LOG2+2], araddr_i[1:0]};

    // Byte-lane SRAM write; bursts flagged as errors never touch the array
    always_ff @(posedge clk) begin
        if (rst_n && w_fire && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb_i[k]) begin
                    mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Write FSM: accept AW, absorb W beats until WLAST, then hold B until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            awready_o <= 1'b1;
            wready_o  <= 1'b0;
            bvalid_o  <= 1'b0;
            bid_o     <= '0;
            bresp_o   <= RESP_OKAY;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_id      <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_id      <= awid_i;
                        w_idx     <= aw_idx;
                        w_len     <= awlen_i;
                        w_cnt     <= '0;
                        w_err     <= aw_err;
                        awready_o <= 1'b0;
                        wready_o  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 5'd1;
                        if (wlast_i) begin
                            wready_o <= 1'b0;
                            bvalid_o <= 1'b1;
                            bid_o    <= w_id;
                            bresp_o  <= (w_err || !w_len_ok) ?
                                        RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_o  <= 1'b0;
                        awready_o <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    awready_o <= 1'b1;
                    wready_o  <= 1'b0;
                    bvalid_o  <= 1'b0;
                    w_state   <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: prefetch one word per accepted beat so a ready master sees no bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rlast_o   <= 1'b0;
            rid_o     <= '0;
            rresp_o   <= RESP_OKAY;
            rdata_o   <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_o     <= arid_i;
                        rresp_o   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_o   <= ar_err ? 32'd0 : rd_word;
                        rlast_o   <= (arlen_i == 4'd0);
                        rvalid_o  <= 1'b1;
                        arready_o <= 1'b0;
                        r_err     <= ar_err;
                        r_len     <= arlen_i;
                        r_beat    <= '0;
                        r_idx     <= ar_idx + 1'b1;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_o) begin
                            rvalid_o  <= 1'b0;
                            rlast_o   <= 1'b0;
                            arready_o <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            rdata_o <= r_err ? 32'd0 : rd_word;
                            rlast_o <= (r_beat_nxt == r_len);
                            r_beat  <= r_beat_nxt;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    arready_o <= 1'b1;
                    rvalid_o  <= 1'b0;
                    rlast_o   <= 1'b0;
                    r_state   <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_sram_responder.sv
// Scoreboard bench for axi3_sram_responder.
// Directed bursts push expected B/R responses; a negedge monitor checks them.
module tb_axi3_sram_responder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awid_i;
    logic [31:0] awaddr_i;
    logic [3:0]  awlen_i;
    logic [2:0]  awsize_i;
    logic [1:0]  awburst_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [3:0]  wid_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic [3:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;

    axi3_sram_responder #(
        .MEM_DEPTH_LOG2(10),
        .ID_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
        .awsize_i(awsize_i), .awburst_i(awburst_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o),
        .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
        .arsize_i(arsize_i), .arburst_i(arburst_i),
        .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];

    int errors = 0;
    int checks = 0;

    bit ignore_r = 0;
    bit rr_toggle = 0;
    bit r_stalled = 0;
    bit b_stalled = 0;
    logic [63:0] r_hold;
    logic [63:0] b_hold;
    r_exp_t re;
    b_exp_t be;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // R channel ready pattern: held high, or toggled every cycle
    initial begin
        rready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_toggle) rready_i = ~rready_i;
            else rready_i = 1'b1;
        end
    end

    // Monitor: pop and compare on every handshake, check stability while stalled
    always @(negedge clk) begin
        if (rst_n && !ignore_r) begin
            if (r_stalled && rvalid_o)
                chk("r_stable", 64'({rid_o, rresp_o, rlast_o, rdata_o}), r_hold);
            if (rvalid_o && rready_i) begin
                if (rq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL r_unexpected: beat data %h, required none", rdata_o);
                end else begin
                    re = rq.pop_front();
                    chk("r_beat", 64'({rid_o, rresp_o, rlast_o, rdata_o}),
                        64'({re.id, re.resp, re.last, re.data}));
                end
            end
        end
        if (rst_n) begin
            if (b_stalled && bvalid_o)
                chk("b_stable", 64'({bid_o, bresp_o}), b_hold);
            if (bvalid_o && bready_i) begin
                if (bq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL b_unexpected: bresp %b, required none", bresp_o);
                end else begin
                    be = bq.pop_front();
                    chk("b_resp", 64'({bid_o, bresp_o}), 64'({be.id, be.resp}));
                end
            end
        end
        r_stalled = rst_n && rvalid_o && !rready_i;
        r_hold    = 64'({rid_o, rresp_o, rlast_o, rdata_o});
        b_stalled = rst_n && bvalid_o && !bready_i;
        b_hold    = 64'({bid_o, bresp_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        bit hs = 0;
        int n = 0;
        awid_i = id; awaddr_i = addr; awlen_i = len;
        awsize_i = size; awburst_i = burst; awvalid_i = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = awready_o;
            tick();
            n++;
        end
        awvalid_i = 1'b0;
        if (!hs) begin
            errors++; checks++;
            $display("FAIL aw_timeout: awready %b, required 1", awready_o);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        bit hs = 0;
        int n = 0;
        arid_i = id; araddr_i = addr; arlen_i = len;
        arsize_i = size; arburst_i = burst; arvalid_i = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = arready_o;
            tick();
            n++;
        end
        arvalid_i = 1'b0;
        if (!hs) begin
            errors++; checks++;
            $display("FAIL ar_timeout: arready %b, required 1", arready_o);
        end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
        bit hs = 0;
        int n = 0;
        wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = wready_o;
            tick();
            n++;
        end
        wvalid_i = 1'b0;
        wlast_i = 1'b0;
        if (!hs) begin
            errors++; checks++;
            $display("FAIL w_timeout: wready %b, required 1", wready_o);
        end
    endtask

    task automatic wait_r_done(input string name);
        int n = 0;
        while (rq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (rq.size() != 0) begin
            errors++; checks++;
            $display("FAIL %s: %0d R beats outstanding, required 0", name, rq.size());
            rq.delete();
        end
    endtask

    task automatic wait_b_done(input string name);
        int n = 0;
        while (bq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (bq.size() != 0) begin
            errors++; checks++;
            $display("FAIL %s: %0d B responses outstanding, required 0", name, bq.size());
            bq.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0;
        awburst_i = '0; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
        bready_i = 1'b1;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0;
        arburst_i = '0; arvalid_i = 1'b0;

        repeat (3) tick();
        chk("rst_ctrl", 64'({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o}),
            64'(6'b110000));
        chk("rst_data", 64'({bid_o, rid_o, bresp_o, rresp_o, rdata_o}), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: four-beat write then read back
        push_b(4'd5, 2'b00);
        send_aw(4'd5, 32'h100, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF, i == 3);
        wait_b_done("t1_b");
        chk("t1_wready_idle", 64'(wready_o), 64'd0);
        for (int i = 0; i < 4; i++) push_r(4'd3, 32'hA0 + i, 2'b00, i == 3);
        send_ar(4'd3, 32'h100, 4'd3, 3'b010, 2'b01);
        wait_r_done("t1_r");

        // 2: partial strobe merge
        push_b(4'd1, 2'b00);
        send_aw(4'd1, 32'h200, 4'd0, 3'b010, 2'b01);
        send_w(32'hFFFF_FFFF, 4'hF, 1'b1);
        wait_b_done("t2_b0");
        push_b(4'd1, 2'b00);
        send_aw(4'd1, 32'h200, 4'd0, 3'b010, 2'b01);
        send_w(32'h1122_3344, 4'b0101, 1'b1);
        wait_b_done("t2_b1");
        push_r(4'd1, 32'hFF22_FF44, 2'b00, 1'b1);
        send_ar(4'd1, 32'h200, 4'd0, 3'b010, 2'b01);
        wait_r_done("t2_r");

        // 3: sixteen-beat read under toggling rready
        push_b(4'd2, 2'b00);
        send_aw(4'd2, 32'h300, 4'd15, 3'b010, 2'b01);
        for (int i = 0; i < 16; i++) send_w(32'h3000 + i, 4'hF, i == 15);
        wait_b_done("t3_b");
        rr_toggle = 1'b1;
        for (int i = 0; i < 16; i++) push_r(4'd4, 32'h3000 + i, 2'b00, i == 15);
        send_ar(4'd4, 32'h300, 4'd15, 3'b010, 2'b01);
        wait_r_done("t3_r");
        rr_toggle = 1'b0;
        tick();

        // 4: unsupported size / burst type
        push_r(4'd2, 32'd0, 2'b10, 1'b0);
        push_r(4'd2, 32'd0, 2'b10, 1'b1);
        send_ar(4'd2, 32'h100, 4'd1, 3'b001, 2'b01);
        wait_r_done("t4_r_err");
        push_b(4'd4, 2'b10);
        send_aw(4'd4, 32'h100, 4'd0, 3'b010, 2'b00);
        send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        wait_b_done("t4_b_err");
        push_r(4'd5, 32'hA0, 2'b00, 1'b1);
        send_ar(4'd5, 32'h100, 4'd0, 3'b010, 2'b01);
        wait_r_done("t4_r_unchanged");

        // 5: early wlast, then index wrap and aliasing
        push_b(4'd6, 2'b10);
        send_aw(4'd6, 32'h400, 4'd3, 3'b010, 2'b01);
        send_w(32'h50, 4'hF, 1'b0);
        send_w(32'h51, 4'hF, 1'b1);
        wait_b_done("t5_b_short");
        push_r(4'd6, 32'h50, 2'b00, 1'b0);
        push_r(4'd6, 32'h51, 2'b00, 1'b1);
        send_ar(4'd6, 32'h400, 4'd1, 3'b010, 2'b01);
        wait_r_done("t5_r_short");
        push_b(4'd7, 2'b00);
        send_aw(4'd7, 32'hFFC, 4'd1, 3'b010, 2'b01);
        send_w(32'h77, 4'hF, 1'b0);
        send_w(32'h78, 4'hF, 1'b1);
        wait_b_done("t5_b_wrap");
        push_r(4'd7, 32'h77, 2'b00, 1'b0);
        push_r(4'd7, 32'h78, 2'b00, 1'b1);
        send_ar(4'd7, 32'hFFC, 4'd1, 3'b010, 2'b01);
        wait_r_done("t5_r_wrap");
        push_r(4'd8, 32'h78, 2'b00, 1'b1);
        send_ar(4'd8, 32'h1000, 4'd0, 3'b010, 2'b01);
        wait_r_done("t5_r_alias");

        // 6: concurrent read/write on one range, B back-pressured
        bready_i = 1'b0;
        push_b(4'd8, 2'b00);
        send_aw(4'd8, 32'h300, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) push_r(4'd9, 32'h3000 + i, 2'b00, i == 3);
        fork
            send_ar(4'd9, 32'h300, 4'd3, 3'b010, 2'b01);
            for (int i = 0; i < 4; i++) send_w(32'h600 + i, 4'hF, i == 3);
        join
        wait_r_done("t6_r_concurrent");
        repeat (5) tick();
        chk("t6_bvalid_held", 64'(bvalid_o), 64'd1);
        chk("t6_b_pending", 64'(bq.size()), 64'd1);
        bready_i = 1'b1;
        wait_b_done("t6_b");
        for (int i = 0; i < 4; i++) push_r(4'd9, 32'h600 + i, 2'b00, i == 3);
        send_ar(4'd9, 32'h300, 4'd3, 3'b010, 2'b01);
        wait_r_done("t6_r_new");

        // reset in the middle of a long read
        ignore_r = 1'b1;
        send_ar(4'd10, 32'h300, 4'd15, 3'b010, 2'b01);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("t6_rst_rvalid", 64'({rvalid_o, rlast_o}), 64'd0);
        chk("t6_rst_ready", 64'({arready_o, awready_o, bvalid_o}), 64'(3'b110));
        rst_n = 1'b1;
        tick();
        ignore_r = 1'b0;
        push_r(4'd11, 32'h600, 2'b00, 1'b1);
        send_ar(4'd11, 32'h300, 4'd0, 3'b010, 2'b01);
        wait_r_done("t6_r_after_rst");
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
